// File: rtl/mult_pkg.sv
// Shared definitions for the iterative shift-add multiplier: FSM state codes
// and the width helper used to size the iteration counter.
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Smallest w such that 2**w >= v (returns 1 for v <= 2 so widths stay legal).
    function automatic int clog2(input int v);
        int w;
        w = 1;
        while ((1 << w) < v) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/seq_mult_ctrl_rca.sv
// N-bit ripple-carry adder row; the single adder that the sequential
// multiplier reuses on every iteration.
module nbit_RCA #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co
);

    // Carry is kept in a block-local variable so the chain is one ordered loop.
    always_comb begin
        logic c;
        c = ci;
        s = '0;
        for (int i = 0; i < N; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end

endmodule

// File: rtl/seq_mult_ctrl.sv
// Iterative unsigned shift-add multiplier: one N-bit adder row reused for M
// cycles, with valid/ready handshakes on the operand and product sides.
module seq_mult_ctrl #(
    parameter int N = 16,
    parameter int M = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [M-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N+M-1:0] p,
    output logic           busy
);
    import mult_pkg::*;

    localparam int            CW   = clog2(M + 1);
    localparam logic [CW-1:0] LAST = CW'(M - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [N-1:0]  a_reg_q;
    logic [N-1:0]  hi_q;
    logic [M-1:0]  lo_q;

    logic          accept, step, last, drain;
    logic [N-1:0]  addend;
    logic [N-1:0]  sum;
    logic          co;
    logic [N-1:0]  hi_nxt;
    logic [M-1:0]  lo_nxt;

    assign addend = lo_q[0] ? a_reg_q : '0;

    nbit_RCA #(.N(N)) u_rca (
        .a  (hi_q),
        .b  (addend),
        .ci (1'b0),
        .s  (sum),
        .co (co)
    );

    // The N+1 bit sum shifts right one place: its LSB becomes the next product
    // bit entering lo from the top while the consumed multiplier bit falls out.
    generate
        if (N > 1) begin : g_hi_wide
            assign hi_nxt = {co, sum[N-1:1]};
        end else begin : g_hi_narrow
            assign hi_nxt = co;
        end
        if (M > 1) begin : g_lo_wide
            assign lo_nxt = {sum[0], lo_q[M-1:1]};
        end else begin : g_lo_narrow
            assign lo_nxt = sum[0];
        end
    endgenerate

    assign in_ready = (state_q == ST_IDLE);
    assign busy     = (state_q == ST_RUN);

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        drain   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (cnt_q == LAST) begin
                    last    = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    drain   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            a_reg_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            p         <= '0;
            out_valid <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_reg_q <= a;
                lo_q    <= b;
                hi_q    <= '0;
                cnt_q   <= '0;
            end
            if (step) begin
                hi_q  <= hi_nxt;
                lo_q  <= lo_nxt;
                cnt_q <= cnt_q + CW'(1);
            end
            // The final iteration's shifted sum is the full product.
            if (last) begin
                p         <= {hi_nxt, lo_nxt};
                out_valid <= 1'b1;
            end
            if (drain) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed and scoreboarded checks of seq_mult_ctrl at 16x16, 8x4 and 8x1.
module tb_seq_mult_ctrl;

    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [15:0] a, b;
    logic [31:0] p;

    logic        iv8, ir8, ov8, or8, bz8;
    logic [7:0]  a8;
    logic [3:0]  b8;
    logic [11:0] p8;

    logic        iv1, ir1, ov1, or1, bz1;
    logic [7:0]  a1;
    logic [0:0]  b1;
    logic [8:0]  p1;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seq_mult_ctrl #(.N(16), .M(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .p(p), .busy(busy)
    );

    seq_mult_ctrl #(.N(8), .M(4)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .out_valid(ov8), .out_ready(or8),
        .p(p8), .busy(bz8)
    );

    seq_mult_ctrl #(.N(8), .M(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
        .a(a1), .b(b1), .out_valid(ov1), .out_ready(or1),
        .p(p1), .busy(bz1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one pair, measure latency, stall for 'stall' cycles, then drain.
    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic [31:0] expv, input int stall);
        int  cyc;
        bit  rdy_seen;
        logic [31:0] held;
        a = av; b = bv; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF;
        cyc = 0;
        rdy_seen = 1'b0;
        while (!out_valid && cyc < 100) begin
            if (in_ready || !busy) rdy_seen = 1'b1;
            tick();
            cyc++;
        end
        chk({tag, "_latency"}, cyc, 16);
        chk({tag, "_ready_low_in_run"}, rdy_seen, 0);
        chk({tag, "_p"}, p, expv);
        held = p;
        for (int i = 0; i < stall; i++) begin
            tick();
            chk({tag, "_stall_valid"}, out_valid, 1);
            chk({tag, "_stall_p"}, p, held);
            chk({tag, "_stall_in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_drain_valid"}, out_valid, 0);
        chk({tag, "_drain_in_ready"}, in_ready, 1);
    endtask

    initial begin
        logic [31:0] q[$];
        logic [31:0] expv;
        int cyc, n_acc, n_done;
        bit acc, drn, ov_seen;

        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0;
        iv1 = 1'b0; or1 = 1'b0; a1 = '0; b1 = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_p", p, 0);

        run_op("basic", 16'h0003, 16'h0005, 32'h0000000F, 0);
        run_op("max", 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 0);
        run_op("zero_b", 16'h1234, 16'h0000, 32'h00000000, 5);

        // Abort in the middle of a run
        a = 16'h00FF; b = 16'h0101; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("midrst_busy_before", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_busy", busy, 0);
        ov_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) ov_seen = 1'b1;
        end
        chk("midrst_no_result", ov_seen, 0);
        run_op("after_rst", 16'h0002, 16'h0003, 32'h00000006, 0);

        // Back-to-back random traffic against a scoreboard
        n_acc = 0; n_done = 0; cyc = 0;
        a = 16'($urandom); b = 16'($urandom);
        in_valid = 1'b1;
        while (n_done < 200 && cyc < 20000) begin
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = (n_acc < 200);
            acc = in_valid && in_ready;
            drn = out_valid && out_ready;
            if (drn) begin
                chk("rand_no_accept_on_drain", in_ready, 0);
                if (q.size() == 0) begin
                    chk("rand_unexpected_result", 1, 0);
                end else begin
                    expv = q.pop_front();
                    chk("rand_p", p, expv);
                end
                n_done++;
            end
            if (acc) begin
                q.push_back(32'(a) * 32'(b));
                n_acc++;
            end
            tick();
            cyc++;
            if (acc) begin
                a = 16'($urandom); b = 16'($urandom);
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("rand_results", n_done, 200);
        chk("rand_queue_empty", q.size(), 0);

        // 8 x 4 configuration
        a8 = 8'hFF; b8 = 4'hF; iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
        cyc = 0;
        while (!ov8 && cyc < 50) begin tick(); cyc++; end
        chk("n8m4_latency", cyc, 4);
        chk("n8m4_p", p8, 12'h0EF1);
        or8 = 1'b1;
        tick();
        or8 = 1'b0;
        chk("n8m4_drain", ov8, 0);

        // 8 x 1 configuration
        a1 = 8'hAB; b1 = 1'b1; iv1 = 1'b1;
        tick();
        iv1 = 1'b0;
        cyc = 0;
        while (!ov1 && cyc < 50) begin tick(); cyc++; end
        chk("m1_latency", cyc, 1);
        chk("m1_p", p1, 9'h0AB);
        or1 = 1'b1;
        tick();
        or1 = 1'b0;
        chk("m1_drain", ov1, 0);
        tick();
        a1 = 8'hAB; b1 = 1'b0; iv1 = 1'b1;
        tick();
        iv1 = 1'b0;
        cyc = 0;
        while (!ov1 && cyc < 50) begin tick(); cyc++; end
        chk("m1_zero_latency", cyc, 1);
        chk("m1_zero_p", p1, 9'h000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
